// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}. Optional early exit: DIV_EARLY_EXIT_EN.
// Latency: ready_o high after edge N+33 (N = accepting edge), N+1 for divide-by-zero or early exit.
// Backpressure: start_i is held until the result is consumed; END holds the result until start_i drops; annul_i flushes.
module div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    dvd;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]    dvs;
    logic                neg_q;
    logic                neg_r;
    logic [2*WIDTH-1:0]  res_hold;

    logic [WIDTH-1:0]    abs1;
    logic [WIDTH-1:0]    abs2;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH-1:0]    rem_sub;
    logic                sub_ok;
    logic [WIDTH-1:0]    q_fin;
    logic [WIDTH-1:0]    r_fin;

    always_comb begin
        abs1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        abs2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        rem_sh  = {rem, dvd[WIDTH-1]};
        sub_ok  = (rem_sh >= {1'b0, dvs});
        // True difference is below dvs whenever it is kept, so WIDTH bits suffice.
        rem_sub = rem_sh[WIDTH-1:0] - dvs;
        q_fin   = neg_q ? -dvd : dvd;
        r_fin   = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            res_hold <= '0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_r <= signed_div_i & opdata1_i[WIDTH-1];
                        dvd   <= abs1;
                        dvs   <= abs2;
                        rem   <= '0;
                        cnt   <= '0;
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (abs2 > abs1) begin
                            // Quotient is zero and the remainder is the untouched dividend.
                            res_hold <= {opdata1_i, {WIDTH{1'b0}}};
                            state    <= END;
                        end
`endif
                        else begin
                            state <= ON;
                        end
                    end
                end

                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        res_hold <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end

                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        res_hold <= {r_fin, q_fin};
                        result_o <= {r_fin, q_fin};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end else begin
                        rem <= sub_ok ? rem_sub : rem_sh[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], sub_ok};
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                END: begin
                    if (annul_i || !start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        state    <= FREE;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= res_hold;
                    end
                end

                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    state    <= FREE;
                end
            endcase
        end
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle divider feeding the execute stage's DIV/DIVU path.
- Execute stage raises start_i with operands, stalls the pipeline while busy, and collects the 64-bit {remainder, quotient} when ready_o is high.
- Execute stage then writes the result to HI/LO.
- Radix-2 restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by the execute stage until it consumes the result.
- annul_i  in  1  cancel current operation (pipeline flush).
- result_o  out  2*WIDTH  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO.
- ready_o  out  1  result valid.

Behaviour:
- Reset: when rst is high at an edge, the FSM goes to FREE, and result_o = 0, ready_o = 0, counter = 0. Reset applies mid-operation too, with no partial result exposed.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0 at edge N: latch signed_div_i and operands; later operand changes are ignored.
  - If the divisor is 0, go to BYZERO.
  - Otherwise go to ON with counter = 0.
  - In signed mode, latch absolute values of negative operands.
  - ready_o = 0, result_o = 0.
- BYZERO: at the next edge go to END with result 0. ready_o = 1 and result_o = 0 after edge N+1.
- ON:
  - Edges N+1..N+32, one iteration each: shift partial remainder left, bring in the next dividend bit, trial-subtract the divisor; if non-negative keep the difference and set the quotient bit to 1, else restore and set it to 0. Counter increments.
  - Edge N+33, counter == WIDTH: sign correction, register result_o, ready_o = 1, go to END.
  - Sign correction (signed mode only): negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (two's-complement negate if the dividend was negative).
  - Unsigned mode: no correction.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed wraps to quotient 0x80000000, remainder 0. No exception is raised.
- END:
  - Hold result_o and ready_o while start_i = 1.
  - On the first edge with start_i = 0: go to FREE, ready_o = 0, result_o = 0.
- annul_i = 1 at any edge in BYZERO, ON or END: go to FREE, ready_o = 0, result_o = 0.
  - annul_i has priority over completion at the same edge.
  - In FREE, start_i with annul_i = 1 is not accepted.
- start_i toggling while in ON or BYZERO is ignored; there is no restart until FREE.
- Latency, start edge N to ready_o high:
  - N+33 for the normal path.
  - N+1 for divide by zero.
  - N+1 for the early-exit path (optional feature).
- ready_o is a registered output only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in FREE, if the divisor is non-zero and |divisor| > |dividend| (unsigned compare of latched magnitudes):
  - Go directly to END at edge N.
  - Quotient = 0, remainder = the original dividend (sign preserved).
  - ready_o = 1 after edge N+1.
- Undefined: this path is absent, all non-zero divisors take the N+33 path, and results are identical.

Test Plan:
- Unsigned 7 / 2, start sampled at edge N -> ready_o rises after edge N+33, result_o = 0x00000001_00000003. Drop start_i -> ready_o = 0 after the next edge.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD. Unsigned 0xFFFFFFF9 / 2 -> result_o = 0x00000001_7FFFFFFC.
- Divisor 0, dividend 0x1234 -> ready_o after edge N+1, result_o = 0. Signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000 at N+33.
- annul_i pulsed at edge N+10 -> FREE, ready_o never rises. New start at N+12 with 100/7 -> result_o = 0x00000002_0000000E after edge N+45.
- rst asserted at edge N+20 mid-ON -> ready_o = 0 and result_o = 0 after that edge. Operands changed during ON have no effect on the result of a fresh start.
- With DIV_EARLY_EXIT_EN: 3 / 10 -> ready_o after edge N+1, result_o = 0x00000003_00000000. Without the macro, the same stimulus gives the same result at N+33.
